sram_sdp_ctrl: RTL and testbench

//   Parametrised simple-dual-port SRAM with one write port and one read port on a single clock.
//   - Write port has byte enables. Read port is registered and has a valid strobe.
//   - Same-cycle write-to-read bypass.
//   - After reset, a sequencer zeroes every word and flags busy until it finishes.

---
 rtl/core_mem_pkg.sv | 20 ++
 rtl/sram_sdp_ctrl_if.sv | 34 +++
 rtl/sram_sdp_array.sv | 31 +++
 rtl/sram_sdp_ctrl.sv | 138 +++++++++++++
 tb/tb_sram_sdp_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/core_mem_pkg.sv
// Shared types and constants for the core-local SDP SRAM controller.
// SRAM_OUTREG_EN (macro) selects the two-stage read pipeline.
package core_mem_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    function automatic int nb(input int data_w, input int byte_w);
        return data_w / byte_w;
    endfunction

`ifdef SRAM_OUTREG_EN
    localparam int READ_LAT = 2;
`else
    localparam int READ_LAT = 1;
`endif

endpackage

// File: rtl/sram_sdp_ctrl_if.sv
// Bus bundle for sram_sdp_ctrl: write port, read port, busy and FSM debug state.
interface sram_sdp_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int BYTE_W = 8
);
    import core_mem_pkg::*;

    localparam int NB = nb(DATA_W, BYTE_W);

    // No backpressure: while busy is low, wr_en and rd_en are accepted on every
    // rising edge; rd_valid is a one-cycle pulse with no ready, one per read, in order.
    logic              busy;
    logic              wr_en;
    logic [NB-1:0]     wr_be;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    state_e            state_dbg;

    modport master (
        output wr_en, wr_be, wr_addr, wr_data, rd_en, rd_addr,
        input  busy, rd_data, rd_valid, state_dbg
    );

    modport slave (
        input  wr_en, wr_be, wr_addr, wr_data, rd_en, rd_addr,
        output busy, rd_data, rd_valid, state_dbg
    );

endinterface

// File: rtl/sram_sdp_array.sv
// Inferred simple-dual-port storage: byte-enabled write, registered read, no reset.
module sram_sdp_array #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int BYTE_W = 8
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [DATA_W/BYTE_W-1:0]   be,
    input  logic [ADDR_W-1:0]          waddr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       re,
    input  logic [ADDR_W-1:0]          raddr,
    output logic [DATA_W-1:0]          rdata
);
    localparam int NB    = DATA_W / BYTE_W;
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // A same-edge read returns the old word; the wrapper merges fresh lanes.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) mem[waddr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
            end
        end
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/sram_sdp_ctrl.sv
// SDP SRAM wrapper: post-reset clear sequencer, write-first bypass, read valid pipeline.
// Define SRAM_OUTREG_EN for an extra output register stage (read latency 2).
module sram_sdp_ctrl
    import core_mem_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 10,
    parameter int BYTE_W     = 8,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    sram_sdp_ctrl_if.slave bus
);
    localparam int NB = nb(DATA_W, BYTE_W);
    localparam state_e RST_STATE = INIT_CLEAR ? ST_CLEAR : ST_READY;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              clearing;
    logic              ready;
    logic              wr_fire, rd_fire;

    logic              arr_we;
    logic [NB-1:0]     arr_be;
    logic [ADDR_W-1:0] arr_waddr;
    logic [DATA_W-1:0] arr_wdata;
    logic [DATA_W-1:0] arr_rdata;

    logic [NB-1:0]     byp_be_q;
    logic [DATA_W-1:0] byp_data_q;
    logic              v1_q;
    logic              live_q;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] s1_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clearing = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clearing = 1'b1;
                cnt_d    = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST_ADDR) state_d = ST_READY;
            end
            ST_READY: state_d = ST_READY;
            default:  state_d = ST_READY;
        endcase
    end

    assign ready         = (state_q == ST_READY);
    assign wr_fire       = bus.wr_en & ready;
    assign rd_fire       = bus.rd_en & ready;
    assign bus.busy      = (state_q == ST_CLEAR);
    assign bus.state_dbg = state_q;

    always_comb begin
        arr_we    = clearing | wr_fire;
        arr_be    = clearing ? '1 : bus.wr_be;
        arr_waddr = clearing ? cnt_q : bus.wr_addr;
        arr_wdata = clearing ? '0 : bus.wr_data;
    end

    sram_sdp_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYTE_W (BYTE_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .be    (arr_be),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .re    (rd_fire),
        .raddr (bus.rd_addr),
        .rdata (arr_rdata)
    );

    // Bypass lanes are captured with the read so the merged word holds with arr_rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_be_q   <= '0;
            byp_data_q <= '0;
            v1_q       <= 1'b0;
            live_q     <= 1'b0;
        end else begin
            v1_q <= rd_fire;
            if (rd_fire) begin
                byp_be_q   <= (wr_fire && (bus.wr_addr == bus.rd_addr)) ? bus.wr_be : '0;
                byp_data_q <= bus.wr_data;
            end
            if (v1_q) live_q <= 1'b1;
        end
    end

    always_comb begin
        merged = arr_rdata;
        for (int i = 0; i < NB; i++) begin
            if (byp_be_q[i]) merged[i*BYTE_W +: BYTE_W] = byp_data_q[i*BYTE_W +: BYTE_W];
        end
        // The array has no reset, so output reads as zero until the first read completes.
        s1_data = (live_q | v1_q) ? merged : '0;
    end

`ifdef SRAM_OUTREG_EN
    logic              v2_q;
    logic [DATA_W-1:0] d2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q <= 1'b0;
            d2_q <= '0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) d2_q <= s1_data;
        end
    end

    assign bus.rd_valid = v2_q;
    assign bus.rd_data  = d2_q;
`else
    assign bus.rd_valid = v1_q;
    assign bus.rd_data  = s1_data;
`endif

endmodule

// File: tb/tb_sram_sdp_ctrl.sv
// Self-checking bench for sram_sdp_ctrl with a reference memory model and read scoreboard.
module tb_sram_sdp_ctrl;
    import core_mem_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int BYTE_W = 8;
    localparam int NB     = 4;
    localparam int DEPTH  = 1024;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sram_sdp_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYTE_W(BYTE_W)) bus ();

    sram_sdp_ctrl #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .BYTE_W     (BYTE_W),
        .INIT_CLEAR (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int                n_checks = 0;
    int                n_fail   = 0;
    int                cyc      = 0;
    int                busy_cycles = 0;
    logic [DATA_W-1:0] exp_q[$];
    int                lat_q[$];
    logic [DATA_W-1:0] model [DEPTH];
    logic [DATA_W-1:0] last_data = '0;
    bit                hold_chk  = 1'b0;
    bit                tb_ready  = 1'b0;

    task automatic check_eq(input string tag, input logic [DATA_W-1:0] act,
                            input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && bus.busy) busy_cycles++;
    end

    // Read scoreboard: every rd_valid pops one expected word and its due cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rd_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_rd_valid", 32'(bus.rd_valid), 32'(0));
                end else begin
                    logic [DATA_W-1:0] d;
                    int                c;
                    d = exp_q.pop_front();
                    c = lat_q.pop_front();
                    check_eq("rd_data", bus.rd_data, d);
                    check_eq("rd_latency", 32'(cyc), 32'(c));
                    last_data = d;
                    hold_chk  = 1'b1;
                end
            end else if (hold_chk) begin
                check_eq("rd_data_hold", bus.rd_data, last_data);
            end
        end
    end

    task automatic drive(input bit we, input logic [NB-1:0] be, input int wa,
                         input logic [DATA_W-1:0] wd, input bit re, input int ra);
        logic [DATA_W-1:0] e;
        bus.wr_en   = we;
        bus.wr_be   = be;
        bus.wr_addr = ADDR_W'(wa);
        bus.wr_data = wd;
        bus.rd_en   = re;
        bus.rd_addr = ADDR_W'(ra);
        if (tb_ready) begin
            if (re) begin
                e = model[ra];
                if (we && (wa == ra)) begin
                    for (int i = 0; i < NB; i++)
                        if (be[i]) e[i*BYTE_W +: BYTE_W] = wd[i*BYTE_W +: BYTE_W];
                end
                exp_q.push_back(e);
                lat_q.push_back(cyc + READ_LAT);
            end
            if (we) begin
                for (int i = 0; i < NB; i++)
                    if (be[i]) model[wa][i*BYTE_W +: BYTE_W] = wd[i*BYTE_W +: BYTE_W];
            end
        end
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.wr_be = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 0, '0, 1'b0, 0);
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        tb_ready  = 1'b0;
        hold_chk  = 1'b0;
        last_data = '0;
        #1;
        check_eq("rst_busy", 32'(bus.busy), 32'(1));
        check_eq("rst_rd_valid", 32'(bus.rd_valid), 32'(0));
        check_eq("rst_rd_data", bus.rd_data, 32'h0);
        check_eq("rst_state", 32'(bus.state_dbg), 32'(ST_CLEAR));
        repeat (2) @(posedge clk);
        #1;
        rst_n       = 1'b1;
        busy_cycles = 0;
    endtask

    task automatic wait_clear();
        for (int i = 0; i < 3000 && bus.busy; i++) begin
            @(posedge clk);
            #1;
        end
        check_eq("clear_done", 32'(bus.busy), 32'(0));
        check_eq("busy_length", 32'(busy_cycles), 32'(DEPTH));
        check_eq("state_ready", 32'(bus.state_dbg), 32'(ST_READY));
        for (int a = 0; a < DEPTH; a++) model[a] = '0;
        tb_ready = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_be   = '0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_en   = 1'b0;
        bus.rd_addr = '0;
        @(posedge clk);
        #1;

        apply_reset();
        // Requests while clearing must be dropped.
        drive(1'b1, 4'b1111, 10, 32'h55, 1'b1, 10);
        drive(1'b1, 4'b1111, 10, 32'h55, 1'b0, 0);
        drive(1'b0, 4'b0000, 0, '0, 1'b1, 10);
        wait_clear();

        drive(1'b0, '0, 0, '0, 1'b1, 10'h3FF);
        idle(3);
        drive(1'b0, '0, 0, '0, 1'b1, 10);
        idle(3);

        drive(1'b1, 4'b1111, 5, 32'hAABBCCDD, 1'b0, 0);
        drive(1'b1, 4'b0010, 5, 32'h11223344, 1'b0, 0);
        drive(1'b0, '0, 0, '0, 1'b1, 5);
        idle(3);
        check_eq("model_addr5", model[5], 32'hAABB33DD);

        drive(1'b1, 4'b1100, 7, 32'hDEADBEEF, 1'b1, 7);
        idle(2);
        drive(1'b0, '0, 0, '0, 1'b1, 7);
        idle(3);

        drive(1'b1, 4'b0000, 5, 32'hFFFFFFFF, 1'b1, 5);
        idle(3);

        for (int a = 0; a < 4; a++) drive(1'b1, 4'b1111, a, 32'(32'h10 + a), 1'b0, 0);
        for (int a = 0; a < 4; a++) drive(1'b0, '0, 0, '0, 1'b1, a);
        idle(4);

        for (int i = 0; i < 60; i++) begin
            drive($urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), $urandom_range(16, 23),
                  $urandom, $urandom_range(0, 1) == 1, $urandom_range(16, 23));
        end
        idle(4);
        check_eq("queue_drained", 32'(exp_q.size()), 32'(0));

        // Reset mid-clear restarts the sequence from address 0.
        apply_reset();
        repeat (500) begin
            @(posedge clk);
            #1;
        end
        check_eq("busy_at_500", 32'(bus.busy), 32'(1));
        apply_reset();
        wait_clear();
        drive(1'b0, '0, 0, '0, 1'b1, 5);
        drive(1'b0, '0, 0, '0, 1'b1, 7);
        drive(1'b0, '0, 0, '0, 1'b1, 3);
        idle(4);

        check_eq("final_queue_empty", 32'(exp_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
